// File: rtl/iob_pcie_chnl_core.sv
// Core-side endpoint of the 64-bit PCIe user channel: drives host-to-FPGA requests on RX,
// accepts and drains FPGA-to-host transfers on TX, bridging both to valid/ready streams.
module iob_pcie_chnl_core #(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int ACK_TIMEOUT      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        dn_start_i,
    input  logic [31:0]                 dn_len_i,
    input  logic [30:0]                 dn_off_i,
    input  logic                        dn_last_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] dn_data_i,
    input  logic                        dn_valid_i,
    output logic                        dn_ready_o,
    output logic                        dn_busy_o,
    output logic                        dn_timeout_o,

    output logic                        CHNL_RX_o,
    output logic                        CHNL_RX_LAST_o,
    output logic [31:0]                 CHNL_RX_LEN_o,
    output logic [30:0]                 CHNL_RX_OFF_o,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA_o,
    output logic                        CHNL_RX_DATA_VALID_o,
    input  logic                        CHNL_RX_DATA_REN_i,
    input  logic                        CHNL_RX_ACK_i,

    input  logic                        CHNL_TX_i,
    input  logic                        CHNL_TX_LAST_i,
    input  logic [31:0]                 CHNL_TX_LEN_i,
    input  logic [30:0]                 CHNL_TX_OFF_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA_i,
    input  logic                        CHNL_TX_DATA_VALID_i,
    output logic                        CHNL_TX_DATA_REN_o,
    output logic                        CHNL_TX_ACK_o,

    output logic [C_PCI_DATA_WIDTH-1:0] up_data_o,
    output logic                        up_valid_o,
    input  logic                        up_ready_i,
    output logic [31:0]                 up_len_o,
    output logic [30:0]                 up_off_o,
    output logic                        up_last_o,
    output logic                        up_done_o,
    output logic                        up_trunc_o
);

    localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

    // 33-bit so that a length of all ones still yields 0x80000000 beats.
    function automatic logic [32:0] beats_of(input logic [31:0] len);
        beats_of = ({1'b0, len} + 33'd1) >> 1;
    endfunction

    typedef enum logic [1:0] {DN_IDLE, DN_REQ, DN_DATA} dn_state_e;
    typedef enum logic [1:0] {UP_IDLE, UP_ACK, UP_DATA, UP_DONE} up_state_e;

    dn_state_e          dn_state_q, dn_state_d;
    logic [31:0]        dn_len_q, dn_len_d;
    logic [30:0]        dn_off_q, dn_off_d;
    logic               dn_last_q, dn_last_d;
    logic [32:0]        dn_cnt_q, dn_cnt_d;
    logic [TMO_W-1:0]   dn_tmo_q, dn_tmo_d;
    logic               dn_timeout_q, dn_timeout_d;
    logic               dn_in_data, dn_xfer;

    up_state_e          up_state_q, up_state_d;
    logic [31:0]        up_len_q, up_len_d;
    logic [30:0]        up_off_q, up_off_d;
    logic               up_last_q, up_last_d;
    logic [32:0]        up_cnt_q, up_cnt_d;
    logic               up_trunc_q, up_trunc_d;
    logic               up_armed_q, up_armed_d;
    logic               up_in_data, up_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_state_q   <= DN_IDLE;
            dn_len_q     <= '0;
            dn_off_q     <= '0;
            dn_last_q    <= 1'b0;
            dn_cnt_q     <= '0;
            dn_tmo_q     <= '0;
            dn_timeout_q <= 1'b0;
        end else begin
            dn_state_q   <= dn_state_d;
            dn_len_q     <= dn_len_d;
            dn_off_q     <= dn_off_d;
            dn_last_q    <= dn_last_d;
            dn_cnt_q     <= dn_cnt_d;
            dn_tmo_q     <= dn_tmo_d;
            dn_timeout_q <= dn_timeout_d;
        end
    end

    assign dn_in_data = (dn_state_q == DN_DATA);
    assign dn_xfer    = dn_in_data & dn_valid_i & CHNL_RX_DATA_REN_i;

    always_comb begin
        dn_state_d   = dn_state_q;
        dn_len_d     = dn_len_q;
        dn_off_d     = dn_off_q;
        dn_last_d    = dn_last_q;
        dn_cnt_d     = dn_cnt_q;
        dn_tmo_d     = dn_tmo_q;
        dn_timeout_d = dn_timeout_q;
        case (dn_state_q)
            DN_IDLE: begin
                if (dn_start_i) begin
                    dn_len_d     = dn_len_i;
                    dn_off_d     = dn_off_i;
                    dn_last_d    = dn_last_i;
                    dn_cnt_d     = beats_of(dn_len_i);
                    dn_tmo_d     = TMO_LOAD;
                    dn_timeout_d = 1'b0;
                    dn_state_d   = DN_REQ;
                end
            end
            DN_REQ: begin
                // Acknowledge has priority over the timer expiring in the same cycle.
                if (CHNL_RX_ACK_i) begin
                    dn_state_d = (dn_cnt_q == 33'd0) ? DN_IDLE : DN_DATA;
                end else if (dn_tmo_q == '0) begin
                    dn_timeout_d = 1'b1;
                    dn_state_d   = DN_IDLE;
                end else begin
                    dn_tmo_d = dn_tmo_q - 1'b1;
                end
            end
            DN_DATA: begin
                if (dn_xfer) begin
                    dn_cnt_d = dn_cnt_q - 33'd1;
                    if (dn_cnt_q == 33'd1) begin
                        dn_state_d = DN_IDLE;
                    end
                end
            end
            default: dn_state_d = DN_IDLE;
        endcase
    end

    assign dn_busy_o            = (dn_state_q != DN_IDLE);
    assign dn_timeout_o         = dn_timeout_q;
    assign dn_ready_o           = dn_xfer;
    assign CHNL_RX_o            = dn_busy_o;
    assign CHNL_RX_LAST_o       = dn_last_q;
    assign CHNL_RX_LEN_o        = dn_len_q;
    assign CHNL_RX_OFF_o        = dn_off_q;
    assign CHNL_RX_DATA_VALID_o = dn_in_data & dn_valid_i;
    assign CHNL_RX_DATA_o       = dn_in_data ? dn_data_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_state_q <= UP_IDLE;
            up_len_q   <= '0;
            up_off_q   <= '0;
            up_last_q  <= 1'b0;
            up_cnt_q   <= '0;
            up_trunc_q <= 1'b0;
            up_armed_q <= 1'b1;
        end else begin
            up_state_q <= up_state_d;
            up_len_q   <= up_len_d;
            up_off_q   <= up_off_d;
            up_last_q  <= up_last_d;
            up_cnt_q   <= up_cnt_d;
            up_trunc_q <= up_trunc_d;
            up_armed_q <= up_armed_d;
        end
    end

    assign up_in_data = (up_state_q == UP_DATA);
    assign up_xfer    = up_in_data & CHNL_TX_DATA_VALID_i & up_ready_i;

    always_comb begin
        up_state_d = up_state_q;
        up_len_d   = up_len_q;
        up_off_d   = up_off_q;
        up_last_d  = up_last_q;
        up_cnt_d   = up_cnt_q;
        up_trunc_d = up_trunc_q;
        up_armed_d = up_armed_q;
        case (up_state_q)
            UP_IDLE: begin
                // A request still held high after completion must drop before re-arming.
                if (!CHNL_TX_i) begin
                    up_armed_d = 1'b1;
                end else if (up_armed_q) begin
                    up_len_d   = CHNL_TX_LEN_i;
                    up_off_d   = CHNL_TX_OFF_i;
                    up_last_d  = CHNL_TX_LAST_i;
                    up_cnt_d   = beats_of(CHNL_TX_LEN_i);
                    up_trunc_d = 1'b0;
                    up_armed_d = 1'b0;
                    up_state_d = UP_ACK;
                end
            end
            UP_ACK: begin
                up_state_d = (up_cnt_q == 33'd0) ? UP_DONE : UP_DATA;
            end
            UP_DATA: begin
                if (up_xfer && (up_cnt_q == 33'd1)) begin
                    up_cnt_d   = 33'd0;
                    up_state_d = UP_DONE;
                end else begin
                    if (up_xfer) begin
                        up_cnt_d = up_cnt_q - 33'd1;
                    end
                    if (!CHNL_TX_i) begin
                        up_trunc_d = 1'b1;
                        up_state_d = UP_DONE;
                    end
                end
            end
            UP_DONE: begin
                up_state_d = UP_IDLE;
            end
            default: up_state_d = UP_IDLE;
        endcase
    end

    assign CHNL_TX_ACK_o      = (up_state_q == UP_ACK);
    assign CHNL_TX_DATA_REN_o = up_in_data & up_ready_i;
    assign up_valid_o         = up_in_data & CHNL_TX_DATA_VALID_i;
    assign up_data_o          = up_in_data ? CHNL_TX_DATA_i : '0;
    assign up_len_o           = up_len_q;
    assign up_off_o           = up_off_q;
    assign up_last_o          = up_last_q;
    assign up_done_o          = (up_state_q == UP_DONE);
    assign up_trunc_o         = up_done_o & up_trunc_q;

endmodule

// File: tb/tb_iob_pcie_chnl_core.sv
// Directed bench for iob_pcie_chnl_core: downstream request/data/timeout paths,
// upstream ack/drain/truncation paths and asynchronous reset.
module tb_iob_pcie_chnl_core;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dn_start_i = 1'b0;
    logic [31:0] dn_len_i = '0;
    logic [30:0] dn_off_i = '0;
    logic        dn_last_i = 1'b0;
    logic [63:0] dn_data_i = '0;
    logic        dn_valid_i = 1'b0;
    logic        dn_ready_o, dn_busy_o, dn_timeout_o;
    logic        CHNL_RX_o, CHNL_RX_LAST_o;
    logic [31:0] CHNL_RX_LEN_o;
    logic [30:0] CHNL_RX_OFF_o;
    logic [63:0] CHNL_RX_DATA_o;
    logic        CHNL_RX_DATA_VALID_o;
    logic        CHNL_RX_DATA_REN_i = 1'b0;
    logic        CHNL_RX_ACK_i = 1'b0;
    logic        CHNL_TX_i = 1'b0;
    logic        CHNL_TX_LAST_i = 1'b0;
    logic [31:0] CHNL_TX_LEN_i = '0;
    logic [30:0] CHNL_TX_OFF_i = '0;
    logic [63:0] CHNL_TX_DATA_i = '0;
    logic        CHNL_TX_DATA_VALID_i = 1'b0;
    logic        CHNL_TX_DATA_REN_o, CHNL_TX_ACK_o;
    logic [63:0] up_data_o;
    logic        up_valid_o;
    logic        up_ready_i = 1'b0;
    logic [31:0] up_len_o;
    logic [30:0] up_off_o;
    logic        up_last_o, up_done_o, up_trunc_o;

    logic [265:0] all_outs;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iob_pcie_chnl_core #(.C_PCI_DATA_WIDTH(64), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .dn_start_i(dn_start_i), .dn_len_i(dn_len_i), .dn_off_i(dn_off_i),
        .dn_last_i(dn_last_i), .dn_data_i(dn_data_i), .dn_valid_i(dn_valid_i),
        .dn_ready_o(dn_ready_o), .dn_busy_o(dn_busy_o), .dn_timeout_o(dn_timeout_o),
        .CHNL_RX_o(CHNL_RX_o), .CHNL_RX_LAST_o(CHNL_RX_LAST_o),
        .CHNL_RX_LEN_o(CHNL_RX_LEN_o), .CHNL_RX_OFF_o(CHNL_RX_OFF_o),
        .CHNL_RX_DATA_o(CHNL_RX_DATA_o), .CHNL_RX_DATA_VALID_o(CHNL_RX_DATA_VALID_o),
        .CHNL_RX_DATA_REN_i(CHNL_RX_DATA_REN_i), .CHNL_RX_ACK_i(CHNL_RX_ACK_i),
        .CHNL_TX_i(CHNL_TX_i), .CHNL_TX_LAST_i(CHNL_TX_LAST_i),
        .CHNL_TX_LEN_i(CHNL_TX_LEN_i), .CHNL_TX_OFF_i(CHNL_TX_OFF_i),
        .CHNL_TX_DATA_i(CHNL_TX_DATA_i), .CHNL_TX_DATA_VALID_i(CHNL_TX_DATA_VALID_i),
        .CHNL_TX_DATA_REN_o(CHNL_TX_DATA_REN_o), .CHNL_TX_ACK_o(CHNL_TX_ACK_o),
        .up_data_o(up_data_o), .up_valid_o(up_valid_o), .up_ready_i(up_ready_i),
        .up_len_o(up_len_o), .up_off_o(up_off_o), .up_last_o(up_last_o),
        .up_done_o(up_done_o), .up_trunc_o(up_trunc_o)
    );

    assign all_outs = {dn_ready_o, dn_busy_o, dn_timeout_o, CHNL_RX_o, CHNL_RX_LAST_o,
                       CHNL_RX_LEN_o, CHNL_RX_OFF_o, CHNL_RX_DATA_o, CHNL_RX_DATA_VALID_o,
                       CHNL_TX_DATA_REN_o, CHNL_TX_ACK_o, up_data_o, up_valid_o,
                       up_len_o, up_off_o, up_last_o, up_done_o, up_trunc_o};

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL reset_release_idle: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_dn_basic();
        dn_valid_i = 1'b1; CHNL_RX_DATA_REN_i = 1'b1;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd6; dn_off_i = 31'd0; dn_last_i = 1'b1;
        @(negedge clk);
        tests++;
        if (dn_busy_o !== 1'b0) begin
            fails++; $display("FAIL dn_basic_pre_busy: got %b expected 0", dn_busy_o);
        end
        @(posedge clk); #1;
        dn_start_i = 1'b0; CHNL_RX_ACK_i = 1'b1;
        @(negedge clk);
        tests++;
        if ({CHNL_RX_o, dn_busy_o, CHNL_RX_DATA_VALID_o, dn_ready_o, CHNL_RX_LAST_o} !== 5'b11001
            || CHNL_RX_LEN_o !== 32'd6) begin
            fails++;
            $display("FAIL dn_basic_req: rx=%b busy=%b vld=%b rdy=%b last=%b len=%0d expected 1 1 0 0 1 6",
                     CHNL_RX_o, dn_busy_o, CHNL_RX_DATA_VALID_o, dn_ready_o, CHNL_RX_LAST_o, CHNL_RX_LEN_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            CHNL_RX_ACK_i = 1'b0;
            dn_data_i = 64'hA5A5_0000_0000_0010 + 64'(i);
            @(negedge clk);
            tests++;
            if (CHNL_RX_DATA_VALID_o !== 1'b1 || dn_ready_o !== 1'b1 || CHNL_RX_o !== 1'b1
                || CHNL_RX_LEN_o !== 32'd6 || CHNL_RX_DATA_o !== 64'hA5A5_0000_0000_0010 + 64'(i)) begin
                fails++;
                $display("FAIL dn_basic_beat%0d: vld=%b rdy=%b rx=%b len=%0d data=%h expected 1 1 1 6 %h",
                         i, CHNL_RX_DATA_VALID_o, dn_ready_o, CHNL_RX_o, CHNL_RX_LEN_o, CHNL_RX_DATA_o,
                         64'hA5A5_0000_0000_0010 + 64'(i));
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (CHNL_RX_o !== 1'b0 || dn_busy_o !== 1'b0 || CHNL_RX_DATA_VALID_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_basic_end: rx=%b busy=%b vld=%b expected 0 0 0",
                     CHNL_RX_o, dn_busy_o, CHNL_RX_DATA_VALID_o);
        end
    endtask

    task automatic test_dn_ren_toggle();
        int beats = 0;
        int viol = 0;
        int cyc = 0;
        dn_valid_i = 1'b1; CHNL_RX_DATA_REN_i = 1'b0;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd5; dn_off_i = 31'd2; dn_last_i = 1'b0;
        @(posedge clk); #1;
        dn_start_i = 1'b0; CHNL_RX_ACK_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            CHNL_RX_ACK_i = 1'b0;
            CHNL_RX_DATA_REN_i = i[0];
            @(negedge clk);
            if (!dn_busy_o) break;
            cyc++;
            if (dn_ready_o && !CHNL_RX_DATA_REN_i) viol++;
            if (dn_ready_o) beats++;
        end
        tests++;
        if (beats !== 3) begin
            fails++; $display("FAIL dn_ren_beats: got %0d expected 3", beats);
        end
        tests++;
        if (viol !== 0) begin
            fails++; $display("FAIL dn_ren_ready_without_ren: got %0d expected 0", viol);
        end
        tests++;
        if (cyc !== 6) begin
            fails++; $display("FAIL dn_ren_data_cycles: got %0d expected 6", cyc);
        end
        CHNL_RX_DATA_REN_i = 1'b1;
    endtask

    task automatic test_dn_zero_len();
        dn_valid_i = 1'b1; CHNL_RX_DATA_REN_i = 1'b1;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd0; dn_off_i = 31'd7; dn_last_i = 1'b0;
        @(posedge clk); #1;
        dn_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (CHNL_RX_o !== 1'b1 || CHNL_RX_DATA_VALID_o !== 1'b0 || CHNL_RX_OFF_o !== 31'd7) begin
                fails++;
                $display("FAIL dn_zero_req%0d: rx=%b vld=%b off=%0d expected 1 0 7",
                         i, CHNL_RX_o, CHNL_RX_DATA_VALID_o, CHNL_RX_OFF_o);
            end
            @(posedge clk); #1;
            CHNL_RX_ACK_i = (i == 2);
        end
        @(negedge clk);
        tests++;
        if (dn_busy_o !== 1'b0 || CHNL_RX_o !== 1'b0 || dn_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_zero_end: busy=%b rx=%b tmo=%b expected 0 0 0",
                     dn_busy_o, CHNL_RX_o, dn_timeout_o);
        end
    endtask

    task automatic test_dn_timeout();
        int hi = 0;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd4; dn_off_i = 31'd0; dn_last_i = 1'b0;
        @(posedge clk); #1;
        dn_start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!CHNL_RX_o) break;
            hi++;
            @(posedge clk); #1;
        end
        tests++;
        if (hi !== TMO) begin
            fails++; $display("FAIL dn_timeout_req_cycles: got %0d expected %0d", hi, TMO);
        end
        tests++;
        if (dn_timeout_o !== 1'b1 || dn_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_timeout_flag: tmo=%b busy=%b expected 1 0", dn_timeout_o, dn_busy_o);
        end
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd0;
        @(posedge clk); #1;
        dn_start_i = 1'b0; CHNL_RX_ACK_i = 1'b1;
        @(negedge clk);
        tests++;
        if (dn_timeout_o !== 1'b0 || CHNL_RX_o !== 1'b1) begin
            fails++;
            $display("FAIL dn_timeout_clear: tmo=%b rx=%b expected 0 1", dn_timeout_o, CHNL_RX_o);
        end
        @(posedge clk); #1;
        CHNL_RX_ACK_i = 1'b0;
        @(negedge clk);
        tests++;
        if (dn_busy_o !== 1'b0 || dn_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_timeout_restart_end: busy=%b tmo=%b expected 0 0", dn_busy_o, dn_timeout_o);
        end
    endtask

    task automatic test_dn_ack_at_expiry();
        dn_valid_i = 1'b1; CHNL_RX_DATA_REN_i = 1'b1;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd2; dn_off_i = 31'd0; dn_last_i = 1'b1;
        @(posedge clk); #1;
        dn_start_i = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            @(posedge clk);
        end
        #1 CHNL_RX_ACK_i = 1'b1;
        @(negedge clk);
        tests++;
        if (CHNL_RX_o !== 1'b1 || CHNL_RX_DATA_VALID_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_expiry_last_req: rx=%b vld=%b expected 1 0", CHNL_RX_o, CHNL_RX_DATA_VALID_o);
        end
        @(posedge clk); #1;
        CHNL_RX_ACK_i = 1'b0;
        @(negedge clk);
        tests++;
        if (CHNL_RX_DATA_VALID_o !== 1'b1 || dn_ready_o !== 1'b1 || dn_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_expiry_ack_wins: vld=%b rdy=%b tmo=%b expected 1 1 0",
                     CHNL_RX_DATA_VALID_o, dn_ready_o, dn_timeout_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (dn_busy_o !== 1'b0 || dn_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL dn_expiry_end: busy=%b tmo=%b expected 0 0", dn_busy_o, dn_timeout_o);
        end
    endtask

    task automatic test_up_stall();
        int idx = 0;
        int beats = 0;
        int cyc = 0;
        int order_err = 0;
        int ack_extra = 0;
        bit done_seen = 1'b0;
        bit xfer = 1'b0;
        CHNL_TX_DATA_VALID_i = 1'b1; up_ready_i = 1'b0;
        @(posedge clk); #1;
        CHNL_TX_i = 1'b1; CHNL_TX_LEN_i = 32'd8; CHNL_TX_OFF_i = 31'd3; CHNL_TX_LAST_i = 1'b1;
        CHNL_TX_DATA_i = 64'hC0DE_0000_0000_0000;
        @(negedge clk);
        tests++;
        if (CHNL_TX_ACK_o !== 1'b0) begin
            fails++; $display("FAIL up_ack_early: got %b expected 0", CHNL_TX_ACK_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (CHNL_TX_ACK_o !== 1'b1 || up_len_o !== 32'd8 || up_off_o !== 31'd3
            || up_last_o !== 1'b1 || up_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL up_ack: ack=%b len=%0d off=%0d last=%b vld=%b expected 1 8 3 1 0",
                     CHNL_TX_ACK_o, up_len_o, up_off_o, up_last_o, up_valid_o);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (xfer) idx++;
            CHNL_TX_DATA_i = 64'hC0DE_0000_0000_0000 + 64'(idx);
            up_ready_i = i[0];
            @(negedge clk);
            if (up_done_o) begin
                done_seen = 1'b1;
                break;
            end
            cyc++;
            if (CHNL_TX_ACK_o) ack_extra++;
            xfer = up_valid_o && CHNL_TX_DATA_REN_o;
            if (xfer) begin
                if (up_data_o !== 64'hC0DE_0000_0000_0000 + 64'(beats)) order_err++;
                beats++;
            end
        end
        tests++;
        if (done_seen !== 1'b1 || cyc !== 8) begin
            fails++; $display("FAIL up_stall_done_timing: seen=%b cycles=%0d expected 1 8", done_seen, cyc);
        end
        tests++;
        if (beats !== 4 || order_err !== 0) begin
            fails++; $display("FAIL up_stall_beats: beats=%0d order_err=%0d expected 4 0", beats, order_err);
        end
        tests++;
        if (up_trunc_o !== 1'b0 || up_len_o !== 32'd8 || ack_extra !== 0) begin
            fails++;
            $display("FAIL up_stall_done_qual: trunc=%b len=%0d extra_ack=%0d expected 0 8 0",
                     up_trunc_o, up_len_o, ack_extra);
        end
        @(posedge clk); #1;
        up_ready_i = 1'b0;
        @(negedge clk);
        tests++;
        if (up_done_o !== 1'b0) begin
            fails++; $display("FAIL up_done_pulse_width: got %b expected 0", up_done_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (CHNL_TX_ACK_o !== 1'b0) begin
            fails++; $display("FAIL up_held_request_reaccepted: ack=%b expected 0", CHNL_TX_ACK_o);
        end
        @(posedge clk); #1;
        CHNL_TX_i = 1'b0;
    endtask

    task automatic test_up_trunc();
        CHNL_TX_DATA_VALID_i = 1'b1; up_ready_i = 1'b1;
        @(posedge clk); #1;
        CHNL_TX_i = 1'b1; CHNL_TX_LEN_i = 32'd8; CHNL_TX_OFF_i = 31'd0; CHNL_TX_LAST_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (CHNL_TX_ACK_o !== 1'b1) begin
            fails++; $display("FAIL up_trunc_ack: got %b expected 1", CHNL_TX_ACK_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            CHNL_TX_DATA_i = 64'h7700 + 64'(i);
            @(negedge clk);
            tests++;
            if (up_valid_o !== 1'b1 || CHNL_TX_DATA_REN_o !== 1'b1 || up_data_o !== 64'h7700 + 64'(i)) begin
                fails++;
                $display("FAIL up_trunc_beat%0d: vld=%b ren=%b data=%h expected 1 1 %h",
                         i, up_valid_o, CHNL_TX_DATA_REN_o, up_data_o, 64'h7700 + 64'(i));
            end
        end
        @(posedge clk); #1;
        CHNL_TX_i = 1'b0; CHNL_TX_DATA_VALID_i = 1'b0;
        @(negedge clk);
        tests++;
        if (up_done_o !== 1'b0) begin
            fails++; $display("FAIL up_trunc_early_done: got %b expected 0", up_done_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (up_done_o !== 1'b1 || up_trunc_o !== 1'b1) begin
            fails++; $display("FAIL up_trunc_flag: done=%b trunc=%b expected 1 1", up_done_o, up_trunc_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (up_done_o !== 1'b0 || up_trunc_o !== 1'b0) begin
            fails++; $display("FAIL up_trunc_after: done=%b trunc=%b expected 0 0", up_done_o, up_trunc_o);
        end
    endtask

    task automatic test_async_reset();
        dn_valid_i = 1'b1; CHNL_RX_DATA_REN_i = 1'b1; dn_data_i = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk); #1;
        dn_start_i = 1'b1; dn_len_i = 32'd20; dn_off_i = 31'd5; dn_last_i = 1'b1;
        @(posedge clk); #1;
        dn_start_i = 1'b0; CHNL_RX_ACK_i = 1'b1;
        @(posedge clk); #1;
        CHNL_RX_ACK_i = 1'b0;
        @(negedge clk);
        tests++;
        if (CHNL_RX_DATA_VALID_o !== 1'b1 || CHNL_RX_LEN_o !== 32'd20) begin
            fails++;
            $display("FAIL rst_precondition_data: vld=%b len=%0d expected 1 20", CHNL_RX_DATA_VALID_o, CHNL_RX_LEN_o);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL rst_async_mid_data: got %h expected 0", all_outs);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (all_outs !== '0) begin
            fails++; $display("FAIL rst_after_release: got %h expected 0", all_outs);
        end
        dn_valid_i = 1'b0; dn_data_i = '0;
    endtask

    initial begin
        test_reset();
        test_dn_basic();
        test_dn_ren_toggle();
        test_dn_zero_len();
        test_dn_timeout();
        test_dn_ack_at_expiry();
        test_up_stall();
        test_up_trunc();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_pcie_chnl_core.md
# iob_pcie_chnl_core

Core-side endpoint of the 64-bit PCIe user-channel protocol. It initiates host-to-FPGA transactions on the channel RX signals, and accepts and drains FPGA-to-host transactions on the channel TX signals. Both directions bridge to simple valid/ready streams. It sits where the PCIe core's channel engine sits, and is also the bench driver for the channel peripheral.

## Interface
- `C_PCI_DATA_WIDTH`, 64, channel data width in bits; only 64 is supported.
- `ACK_TIMEOUT`, 1024, cycles to wait for the RX acknowledge before aborting.
- `clk`  in  1  system clock; the block has one clock and everything is synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `dn_start_i`  in  1  one-cycle pulse that starts a host-to-FPGA transaction; ignored unless the downstream FSM is in IDLE.
- `dn_len_i`  in  32  transaction length in 32-bit words; sampled on `dn_start_i`.
- `dn_off_i`  in  31  offset in 32-bit words; sampled on `dn_start_i`.
- `dn_last_i`  in  1  last-in-sequence flag; sampled on `dn_start_i`.
- `dn_data_i`  in  64  downstream payload.
- `dn_valid_i`  in  1  downstream payload valid.
- `dn_ready_o`  out  1  downstream payload consumed.
- `dn_busy_o`  out  1  downstream FSM is not in IDLE.
- `dn_timeout_o`  out  1  sticky acknowledge-timeout flag; cleared by the next accepted `dn_start_i`.
- `CHNL_RX_o`, `CHNL_RX_LAST_o`  out  1  channel RX request and last flag.
- `CHNL_RX_LEN_o`  out  32  channel RX length.
- `CHNL_RX_OFF_o`  out  31  channel RX offset.
- `CHNL_RX_DATA_o`  out  64  channel RX data.
- `CHNL_RX_DATA_VALID_o`  out  1  channel RX data valid.
- `CHNL_RX_DATA_REN_i`, `CHNL_RX_ACK_i`  in  1  user-side read enable and acknowledge.
- `CHNL_TX_i`, `CHNL_TX_LAST_i`  in  1  user-side TX request and last flag.
- `CHNL_TX_LEN_i`  in  32  TX length in 32-bit words.
- `CHNL_TX_OFF_i`  in  31  TX offset in 32-bit words.
- `CHNL_TX_DATA_i`  in  64  TX data.
- `CHNL_TX_DATA_VALID_i`  in  1  TX data valid.
- `CHNL_TX_DATA_REN_o`, `CHNL_TX_ACK_o`  out  1  TX read enable and acknowledge toward the user side.
- `up_data_o`  out  64  upstream payload.
- `up_valid_o`  out  1  upstream payload valid.
- `up_ready_i`  in  1  upstream sink ready.
- `up_len_o`  out  32  latched TX length.
- `up_off_o`  out  31  latched TX offset.
- `up_last_o`  out  1  latched TX last flag.
- `up_done_o`  out  1  one-cycle pulse at the end of every upstream transaction.
- `up_trunc_o`  out  1  qualifies `up_done_o`: high when the TX request dropped before all beats were received.

## Operation
- Beat count = (len + 1) >> 1, computed at 33 bits so len = 0xFFFFFFFF gives 0x80000000 beats.
- For odd lengths the upper 32 bits of the final beat are don't-care.
- Reset (async, any state): both FSMs go to IDLE, counters clear, all outputs 0.
- Downstream FSM, IDLE → REQ → DATA → IDLE:
  - IDLE: an accepted `dn_start_i` latches len, off and last, loads the beat counter and clears `dn_timeout_o`, then goes to REQ.
  - REQ: `CHNL_RX_o` = 1. The LEN, OFF and LAST outputs are driven from the latched values and stay stable until return to IDLE.
  - REQ → DATA on `CHNL_RX_ACK_i`. If the beat count is 0, REQ → IDLE instead.
  - REQ → IDLE after `ACK_TIMEOUT` cycles without acknowledge; this sets `dn_timeout_o`.
  - DATA: `CHNL_RX_DATA_VALID_o` = `dn_valid_i`; `CHNL_RX_DATA_o` = `dn_data_i`; `dn_ready_o` = `dn_valid_i & CHNL_RX_DATA_REN_i`.
  - A beat transfers when VALID & REN; the counter decrements. The final transfer → IDLE.
  - Valid and ready are forced 0 outside DATA.
- Upstream FSM, IDLE → ACK → DATA → DONE → IDLE:
  - IDLE: `CHNL_TX_i` high latches `CHNL_TX_LEN_i`, `CHNL_TX_OFF_i` and `CHNL_TX_LAST_i`, loads the counter, then goes to ACK.
  - ACK: `CHNL_TX_ACK_o` = 1 for exactly one cycle. Then DATA, or DONE if the count is 0.
  - DATA: `up_valid_o` = `CHNL_TX_DATA_VALID_i`; `up_data_o` = `CHNL_TX_DATA_i`; `CHNL_TX_DATA_REN_o` = `up_ready_i`.
  - A beat transfers on TX valid & REN; the final beat → DONE.
  - `CHNL_TX_i` low while in DATA → DONE with `up_trunc_o` = 1.
  - DONE: `up_done_o` pulses for one cycle, then IDLE. A new request is accepted only after `CHNL_TX_i` has been seen low in IDLE, so a request held high is not re-accepted.
- The two directions are fully independent and may run concurrently.

## Timing
- Downstream request: `dn_start_i` at cycle n → `CHNL_RX_o` and `dn_busy_o` high at n+1.
- Downstream data: ack sampled at cycle m → DATA at m+1. Data-path signals are combinational inside DATA, so transfer is zero-latency and one beat per cycle is sustained.
- `CHNL_RX_o` falls in the cycle after the final beat transfer.
- `CHNL_TX_i` sampled high in IDLE at cycle k:
  - `CHNL_TX_ACK_o` high at k+1.
  - DATA from k+2.
  - `up_done_o` one cycle after the final beat.
- Timeout: `CHNL_RX_o` high for exactly `ACK_TIMEOUT` cycles; `dn_timeout_o` rises together with the return to IDLE.
- An acknowledge arriving in the same cycle as the timeout expiry wins: the FSM goes to DATA and no timeout is flagged.

## Test plan
- Downstream len=6, off=0, last=1, source always valid, REN always high → 3 beats in 3 consecutive DATA cycles. `CHNL_RX_LEN_o` = 6 throughout; `CHNL_RX_o` low the cycle after the third beat.
- Downstream len=5 with REN toggling every cycle → exactly 3 beats consumed; `dn_ready_o` is never high while REN is low.
- Downstream len=0 → `CHNL_RX_o` high until ack, no valid cycles, `dn_busy_o` low the cycle after ack.
- No ack with `ACK_TIMEOUT`=16 → `CHNL_RX_o` high for 16 cycles, then `dn_timeout_o` = 1. A subsequent `dn_start_i` clears it.
- Upstream `CHNL_TX_LEN_i`=8, sink stalls every other cycle:
  - one-cycle ack at k+1;
  - 4 beats delivered in order;
  - `up_done_o` pulses with `up_trunc_o` = 0;
  - `up_len_o` = 8.
- Upstream len=8 with `CHNL_TX_i` dropped after 2 beats → `up_done_o` pulses with `up_trunc_o` = 1. An asynchronous `rst` applied mid-DATA on the downstream side returns every output to 0 immediately.
